// File: rtl/axi_mgr_wr_pkg.sv
// Local types and helpers for the AXI write manager.
package axi_mgr_wr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } mgr_state_e;

  // True when a burst starting at this page offset stays inside one 4KB page.
  function automatic logic burst_fits_page(input logic [11:0] offset,
                                           input logic [7:0]  len,
                                           input int          bc);
    return ((int'(offset) + (int'(len) + 1) * bc) <= 4096);
  endfunction

endpackage

// File: rtl/axi_pkg.sv
// Shared AXI channel encodings and field widths used by the fabric-facing blocks.
package axi_pkg;

  localparam int AXI_LEN_W  = 8;
  localparam int AXI_SIZE_W = 3;
  localparam int AXI_RESP_W = 2;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10,
    AXI_BURST_RSVD  = 2'b11
  } axi_burst_e;

  typedef enum logic [AXI_RESP_W-1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

endpackage

// File: rtl/axi_if.sv
// AXI write-side channel bundle (AW/W/B) with the manager-side modport.
interface axi_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int UW = 32,
  parameter int IW = 1
);
  localparam int BC = DW / 8;

  logic                               awvalid;
  logic                               awready;
  logic [AW-1:0]                      awaddr;
  logic [axi_pkg::AXI_LEN_W-1:0]      awlen;
  logic [axi_pkg::AXI_SIZE_W-1:0]     awsize;
  axi_pkg::axi_burst_e                awburst;
  logic [UW-1:0]                      awuser;
  logic [IW-1:0]                      awid;
  logic                               awlock;

  logic                               wvalid;
  logic                               wready;
  logic [DW-1:0]                      wdata;
  logic [BC-1:0]                      wstrb;
  logic                               wlast;

  logic                               bvalid;
  logic                               bready;
  axi_pkg::axi_resp_e                 bresp;
  logic [IW-1:0]                      bid;

  modport w_mgr (
    output awvalid, awaddr, awlen, awsize, awburst, awuser, awid, awlock,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

endinterface

// File: rtl/axi_mgr_wr.sv
// AXI write manager: one outstanding INCR write burst, AW -> W -> B sequenced by a small FSM,
// with the B response handed back to the requesting component.
module axi_mgr_wr
  import axi_pkg::*;
  import axi_mgr_wr_pkg::*;
#(
  parameter  int AW = 32,
  parameter  int DW = 32,
  parameter  int UW = 32,
  parameter  int IW = 1,
  localparam int BC = DW / 8,
  localparam int BW = $clog2(BC)
) (
  input  logic          clk,
  input  logic          rst,
  axi_if.w_mgr          m_axi_if,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [7:0]    req_len,
  input  logic [UW-1:0] req_user,
  input  logic [IW-1:0] req_id,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  input  logic [BC-1:0] wr_strb,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output axi_resp_e     rsp_resp,
  output logic [IW-1:0] rsp_id
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [UW-1:0] user;
    logic [IW-1:0] id;
  } ctx_t;

  mgr_state_e state, state_nxt;
  ctx_t       ctx;
  logic [7:0] beat_cnt;
  logic       req_fire;
  logic       w_fire;
  logic       b_fire;

  assign req_fire = req_valid && req_ready;
  assign w_fire   = m_axi_if.wvalid && m_axi_if.wready;
  assign b_fire   = m_axi_if.bvalid && m_axi_if.bready;

  // AW fields come straight from the latched context, so they hold for the whole ADDR stall.
  assign m_axi_if.awaddr  = ctx.addr;
  assign m_axi_if.awlen   = ctx.len;
  assign m_axi_if.awsize  = AXI_SIZE_W'(BW);
  assign m_axi_if.awburst = AXI_BURST_INCR;
  assign m_axi_if.awuser  = ctx.user;
  assign m_axi_if.awid    = ctx.id;
  assign m_axi_if.awlock  = 1'b0;

  assign m_axi_if.wdata   = wr_data;
  assign m_axi_if.wstrb   = wr_strb;
  assign m_axi_if.wlast   = (beat_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    req_ready        = 1'b0;
    wr_ready         = 1'b0;
    m_axi_if.awvalid = 1'b0;
    m_axi_if.wvalid  = 1'b0;
    m_axi_if.bready  = 1'b0;
    case (state)
      IDLE: begin
        // The registered rsp_valid gates acceptance, giving one bubble after a consume.
        req_ready = !rsp_valid && !rst;
        if (req_valid && req_ready) state_nxt = ADDR;
      end
      ADDR: begin
        m_axi_if.awvalid = 1'b1;
        if (m_axi_if.awready) state_nxt = DATA;
      end
      DATA: begin
        m_axi_if.wvalid = wr_valid;
        wr_ready        = m_axi_if.wready;
        if (wr_valid && m_axi_if.wready && (beat_cnt == 8'd0)) state_nxt = RESP;
      end
      RESP: begin
        m_axi_if.bready = 1'b1;
        if (m_axi_if.bvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctx      <= '0;
      beat_cnt <= '0;
    end else if (req_fire) begin
      ctx.addr <= req_addr;
      ctx.len  <= req_len;
      ctx.user <= req_user;
      ctx.id   <= req_id;
      beat_cnt <= req_len;
    end else if (w_fire && (beat_cnt != 8'd0)) begin
      beat_cnt <= beat_cnt - 8'd1;
    end
  end

  // Response is held for the component; IDLE refuses new work until it is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_resp  <= AXI_RESP_OKAY;
      rsp_id    <= '0;
    end else if (b_fire) begin
      rsp_valid <= 1'b1;
      rsp_resp  <= m_axi_if.bresp;
      rsp_id    <= m_axi_if.bid;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  a_known_handshake: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({req_valid, req_ready, wr_valid, wr_ready, rsp_valid, rsp_ready,
                 m_axi_if.awvalid, m_axi_if.awready, m_axi_if.wvalid, m_axi_if.wready,
                 m_axi_if.bvalid, m_axi_if.bready}));

  a_aw_stable: assert property (@(posedge clk) disable iff (rst)
    (m_axi_if.awvalid && !m_axi_if.awready) |=>
      (m_axi_if.awvalid &&
       $stable({m_axi_if.awaddr, m_axi_if.awlen, m_axi_if.awsize, m_axi_if.awburst,
                m_axi_if.awuser, m_axi_if.awid, m_axi_if.awlock})));

  a_w_stable: assert property (@(posedge clk) disable iff (rst)
    (m_axi_if.wvalid && !m_axi_if.wready) |=>
      (m_axi_if.wvalid && $stable({m_axi_if.wdata, m_axi_if.wstrb, m_axi_if.wlast})));

  a_req_aligned: assert property (@(posedge clk) disable iff (rst)
    req_valid |-> ((req_addr % BC) == 0));

  a_req_4k: assert property (@(posedge clk) disable iff (rst)
    req_valid |-> burst_fits_page(req_addr[11:0], req_len, BC));

  a_b_only_in_resp: assert property (@(posedge clk) disable iff (rst)
    b_fire |-> (state == RESP));

endmodule

// File: tb/tb_axi_mgr_wr.sv
// Directed-plus-random bench for axi_mgr_wr acting as the AXI subordinate and the requesting component.
module tb_axi_mgr_wr;
  import axi_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [31:0] req_user;
  logic        req_id;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  axi_resp_e   rsp_resp;
  logic        rsp_id;

  int checks = 0;
  int errors = 0;

  logic [31:0] cur_addr;
  logic [7:0]  cur_len;
  logic        cur_id;
  logic [31:0] cur_user;
  logic [31:0] d [256];
  logic [3:0]  s [256];

  axi_if #(.AW(32), .DW(32), .UW(32), .IW(1)) axi ();

  axi_mgr_wr #(.AW(32), .DW(32), .UW(32), .IW(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .m_axi_if  (axi),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_user  (req_user),
    .req_id    (req_id),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_resp  (rsp_resp),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr(input logic [7:0] len);
    int max_off;
    logic [31:0] page;
    max_off = (4096 - (int'(len) + 1) * 4) / 4;
    page    = $urandom & 32'hFFFF_F000;
    return page | (32'($urandom_range(0, max_off)) << 2);
  endfunction

  task automatic set_req(input logic [31:0] a, input logic [7:0] l, input logic i,
                         input logic [31:0] u);
    cur_addr = a; cur_len = l; cur_id = i; cur_user = u;
    req_addr = a; req_len = l; req_id = i; req_user = u;
    for (int k = 0; k <= int'(l); k++) begin
      d[k] = $urandom;
      s[k] = 4'($urandom_range(1, 15));
    end
  endtask

  task automatic accept();
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    req_valid = 1'b1;
    wr_valid  = 1'b1;
    wr_data   = d[0];
    wr_strb   = s[0];
    while (!got && cyc < 20) begin
      @(negedge clk);
      got = req_ready;
      step();
      cyc++;
    end
    req_valid = 1'b0;
    chk("req_accept", 128'(got), 128'(1));
  endtask

  // Runs AW, W, B and response phases of the already-accepted request described by cur_*.
  task automatic run_txn(input int aw_stall, input int wmode, input int abort,
                         input axi_resp_e br, input logic bi, input int hold,
                         input bit pend, input logic [31:0] p_addr, input logic [7:0] p_len,
                         input logic p_id, input logic [31:0] p_user);
    int  cyc;
    int  beat;
    int  dly;
    bit  done;
    bit  hs;
    // AW phase
    cyc  = 0;
    done = 1'b0;
    axi.awready = (aw_stall == 0);
    while (!done && cyc < 50) begin
      @(negedge clk);
      chk("aw_valid", 128'(axi.awvalid), 128'(1));
      chk("aw_fields",
          {axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awuser, axi.awid, axi.awlock},
          {cur_addr, cur_len, 3'd2, AXI_BURST_INCR, cur_user, cur_id, 1'b0});
      chk("aw_wstall", {axi.wvalid, wr_ready}, 2'b00);
      done = axi.awvalid && axi.awready;
      step();
      cyc++;
      axi.awready = (cyc >= aw_stall);
    end
    axi.awready = 1'b0;
    chk("aw_done", 128'(done), 128'(1));
    // W phase
    beat = 0;
    cyc  = 0;
    axi.wready = (wmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (beat <= int'(cur_len) && cyc < 3000) begin
      @(negedge clk);
      chk("w_valid", {axi.wvalid, wr_ready}, {1'b1, axi.wready});
      chk("w_beat", {axi.wdata, axi.wstrb, axi.wlast},
          {d[beat], s[beat], (beat == int'(cur_len))});
      hs = axi.wvalid && axi.wready;
      step();
      cyc++;
      if (hs) begin
        beat++;
        if (beat <= int'(cur_len)) begin
          wr_data = d[beat];
          wr_strb = s[beat];
        end else begin
          wr_valid = 1'b0;
        end
      end
      if (abort >= 0 && beat == abort) begin
        rst = 1'b1;
        axi.wready = 1'b0;
        step();
        @(negedge clk);
        chk("rst_mid_outs",
            {axi.awvalid, axi.wvalid, axi.bready, rsp_valid, wr_ready, req_ready}, 6'b0);
        step();
        rst = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle", {req_ready, axi.awvalid, axi.wvalid, rsp_valid}, 4'b1000);
        step();
        return;
      end
      case (wmode)
        1:       axi.wready = (cyc % 2 == 0);
        2:       axi.wready = 1'($urandom_range(0, 1));
        default: axi.wready = 1'b1;
      endcase
    end
    axi.wready = 1'b0;
    chk("w_count", 128'(beat), 128'(int'(cur_len) + 1));
    // B phase
    dly = $urandom_range(0, 2);
    for (int i = 0; i <= dly; i++) begin
      @(negedge clk);
      chk("resp_wait", {axi.bready, axi.wvalid, wr_ready, rsp_valid}, 4'b1000);
      step();
    end
    axi.bvalid = 1'b1;
    axi.bresp  = br;
    axi.bid    = bi;
    @(negedge clk);
    chk("b_ready", 128'(axi.bready), 128'(1));
    step();
    axi.bvalid = 1'b0;
    axi.bresp  = AXI_RESP_OKAY;
    // Response hold towards the component
    if (pend) begin
      set_req(p_addr, p_len, p_id, p_user);
      req_valid = 1'b1;
      wr_valid  = 1'b1;
      wr_data   = d[0];
      wr_strb   = s[0];
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold", {rsp_valid, rsp_resp, rsp_id}, {1'b1, br, bi});
      chk("rsp_block", {req_ready, axi.awvalid}, 2'b00);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_take", {rsp_valid, rsp_resp, rsp_id}, {1'b1, br, bi});
    chk("rsp_bubble", 128'(req_ready), 128'(0));
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_clear", {rsp_valid, req_ready}, 2'b01);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]  l;
    logic [31:0] a;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_user  = '0;
    req_id    = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    wr_strb   = '0;
    rsp_ready = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = AXI_RESP_OKAY;
    axi.bid     = 1'b0;

    // Reset state
    step();
    step();
    @(negedge clk);
    chk("reset_outs", {axi.awvalid, axi.wvalid, axi.bready, rsp_valid, req_ready, wr_ready},
        6'b0);
    chk("reset_rsp", {rsp_resp, rsp_id}, 3'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 128'(req_ready), 128'(1));
    step();

    // 1: single beat
    set_req(32'h0000_1000, 8'd0, 1'b1, 32'h1234_5678);
    d[0] = 32'hDEAD_BEEF;
    s[0] = 4'hF;
    accept();
    run_txn(0, 0, -1, AXI_RESP_OKAY, 1'b1, 0, 1'b0, '0, '0, 1'b0, '0);

    // 2: four beats with wready toggling
    set_req(32'h0000_2040, 8'd3, 1'b0, 32'hA5A5_0001);
    accept();
    run_txn(0, 1, -1, AXI_RESP_OKAY, 1'b0, 0, 1'b0, '0, '0, 1'b0, '0);

    // 3: AW backpressure for five cycles
    set_req(32'h0003_0FF0, 8'd2, 1'b1, 32'h0000_00C3);
    accept();
    run_txn(5, 0, -1, AXI_RESP_OKAY, 1'b1, 0, 1'b0, '0, '0, 1'b0, '0);

    // 4: SLVERR passed through
    set_req(32'h0004_0000, 8'd1, 1'b0, 32'h0);
    accept();
    run_txn(0, 0, -1, AXI_RESP_SLVERR, 1'b0, 0, 1'b0, '0, '0, 1'b0, '0);

    // 5: response held three cycles with the next request pending
    set_req(32'h0005_0100, 8'd0, 1'b1, 32'h5);
    accept();
    run_txn(1, 0, -1, AXI_RESP_DECERR, 1'b1, 3, 1'b1, 32'h0006_0200, 8'd1, 1'b0, 32'h6);
    run_txn(0, 0, -1, AXI_RESP_OKAY, 1'b0, 0, 1'b0, '0, '0, 1'b0, '0);

    // 6: reset in DATA after two of four beats, then a clean transfer
    set_req(32'h0007_0000, 8'd3, 1'b1, 32'h7);
    accept();
    run_txn(0, 0, 2, AXI_RESP_OKAY, 1'b1, 0, 1'b0, '0, '0, 1'b0, '0);
    set_req(32'h0008_0010, 8'd2, 1'b1, 32'h8);
    accept();
    run_txn(0, 0, -1, AXI_RESP_OKAY, 1'b1, 0, 1'b0, '0, '0, 1'b0, '0);

    // Randomised transfers, the first one a full 256-beat burst
    for (int n = 0; n < 8; n++) begin
      l = (n == 0) ? 8'd255 : 8'($urandom_range(0, 15));
      a = rand_addr(l);
      set_req(a, l, 1'($urandom_range(0, 1)), $urandom);
      accept();
      run_txn($urandom_range(0, 3), 2, -1, axi_resp_e'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, '0, '0, 1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
